// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard transmit scheduler:
// host command codes, device reply codes and the response queue layout.
package ps2_kbd_pkg;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_SETLED  = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_DISABLE = 8'hF5;
    localparam logic [7:0] CMD_READID  = 8'hF2;
    localparam logic [7:0] CMD_RESEND  = 8'hFE;

    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_BAT     = 8'hAA;
    localparam logic [7:0] RSP_ECHO    = 8'hEE;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;
    localparam logic [7:0] RSP_ID0     = 8'hAB;
    localparam logic [7:0] RSP_ID1     = 8'h83;

    // bytes[0] is the head of the queue
    typedef struct packed {
        logic [2:0][7:0] bytes;
        logic [1:0]      count;
    } resp_q_t;

endpackage

// File: rtl/ps2_cmd_decoder.sv
// Combinational decode of one host byte into a reply list plus LED,
// scan-enable and argument-wait update strobes.
module ps2_cmd_decoder
    import ps2_kbd_pkg::*;
(
    input  logic [7:0]  host_data,
    input  logic        wait_arg,
    input  logic [7:0]  last_tx,
    output logic [23:0] resp_bytes,
    output logic [1:0]  resp_count,
    output logic        flush,
    output logic        led_wr,
    output logic [2:0]  led_val,
    output logic        scan_wr,
    output logic        scan_val,
    output logic        wait_wr,
    output logic        wait_val
);

    always_comb begin
        resp_bytes = '0;
        resp_count = 2'd0;
        flush      = 1'b0;
        led_wr     = 1'b0;
        led_val    = 3'b000;
        scan_wr    = 1'b0;
        scan_val   = 1'b0;
        wait_wr    = 1'b0;
        wait_val   = 1'b0;
        if (wait_arg && !host_data[7]) begin
            led_wr     = 1'b1;
            led_val    = host_data[2:0];
            resp_bytes = {16'h0000, RSP_ACK};
            resp_count = 2'd1;
            flush      = 1'b1;
            wait_wr    = 1'b1;
        end else if (host_data[7]) begin
            // a command byte always ends a pending LED argument wait
            wait_wr = wait_arg;
            case (host_data)
                CMD_RESET: begin
                    resp_bytes = {8'h00, RSP_BAT, RSP_ACK};
                    resp_count = 2'd2;
                    flush      = 1'b1;
                    led_wr     = 1'b1;
                    scan_wr    = 1'b1;
                    scan_val   = 1'b1;
                    wait_wr    = 1'b1;
                end
                CMD_ECHO: begin
                    resp_bytes = {16'h0000, RSP_ECHO};
                    resp_count = 2'd1;
                    flush      = 1'b1;
                end
                CMD_SETLED: begin
                    resp_bytes = {16'h0000, RSP_ACK};
                    resp_count = 2'd1;
                    flush      = 1'b1;
                    wait_wr    = 1'b1;
                    wait_val   = 1'b1;
                end
                CMD_ENABLE, CMD_DISABLE: begin
                    resp_bytes = {16'h0000, RSP_ACK};
                    resp_count = 2'd1;
                    flush      = 1'b1;
                    scan_wr    = 1'b1;
                    scan_val   = (host_data == CMD_ENABLE);
                end
                CMD_READID: begin
                    resp_bytes = {RSP_ID1, RSP_ID0, RSP_ACK};
                    resp_count = 2'd3;
                    flush      = 1'b1;
                end
                CMD_RESEND: begin
                    // resend leaves any pending replies in place
                    resp_bytes = {16'h0000, last_tx};
                    resp_count = 2'd1;
                end
                default: begin
                    resp_bytes = {16'h0000, RSP_RESEND};
                    resp_count = 2'd1;
                    flush      = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_scheduler.sv
// Shares the PS/2 device-to-host channel between host-command replies
// (strict priority) and the key scancode stream, with a minimum inter-byte gap.
module ps2_kbd_scheduler
    import ps2_kbd_pkg::*;
#(
    parameter int GAP_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_scancode,
    input  logic       key_send,
    output logic       key_ready,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_send,
    output logic [2:0] leds,
    output logic       scan_enabled
);

    localparam int CW = $clog2(GAP_CYCLES + 1);

    logic          tx_send_reg, tx_send_next;
    logic [7:0]    tx_data_reg, tx_data_next;
    logic [2:0]    leds_reg;
    logic          scan_en_reg;
    logic          wait_arg_reg;
    logic [7:0]    last_tx_reg;
    logic [CW-1:0] gap_cnt_reg;
    resp_q_t       q_reg, q_base, q_next;

    logic [23:0] dec_bytes;
    logic [1:0]  dec_count;
    logic        dec_flush, dec_led_wr, dec_scan_wr, dec_scan_val;
    logic        dec_wait_wr, dec_wait_val;
    logic [2:0]  dec_led_val;
    logic [7:0]  dec_byte [3];
    logic        channel_free;

    ps2_cmd_decoder u_dec (
        .host_data  (host_data),
        .wait_arg   (wait_arg_reg),
        .last_tx    (last_tx_reg),
        .resp_bytes (dec_bytes),
        .resp_count (dec_count),
        .flush      (dec_flush),
        .led_wr     (dec_led_wr),
        .led_val    (dec_led_val),
        .scan_wr    (dec_scan_wr),
        .scan_val   (dec_scan_val),
        .wait_wr    (dec_wait_wr),
        .wait_val   (dec_wait_val)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
        assign dec_byte[gi] = dec_bytes[gi*8 +: 8];
    end

    assign channel_free = tx_ready && (gap_cnt_reg == '0) && !tx_send_reg;
    assign key_ready    = reset && channel_free && (q_reg.count == 2'd0)
                          && scan_en_reg && !host_valid;

    always_comb begin
        q_base       = q_reg;
        tx_send_next = 1'b0;
        tx_data_next = tx_data_reg;
        if (channel_free && q_reg.count != 2'd0) begin
            tx_send_next = 1'b1;
            tx_data_next = q_reg.bytes[0];
            q_base.bytes = {8'h00, q_reg.bytes[2:1]};
            q_base.count = q_reg.count - 2'd1;
        end else if (key_send && key_ready) begin
            tx_send_next = 1'b1;
            tx_data_next = key_scancode;
        end
        // a flushing command replaces whatever is left after this cycle's pop
        q_next = q_base;
        if (host_valid) begin
            if (dec_flush) q_next = '0;
            for (int i = 0; i < 3; i++) begin
                if (i < int'(dec_count) && q_next.count != 2'd3) begin
                    q_next.bytes[q_next.count] = dec_byte[i];
                    q_next.count = q_next.count + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_send_reg  <= 1'b0;
            tx_data_reg  <= 8'h00;
            leds_reg     <= 3'b000;
            scan_en_reg  <= 1'b1;
            wait_arg_reg <= 1'b0;
            last_tx_reg  <= 8'h00;
            gap_cnt_reg  <= '0;
            q_reg        <= '0;
        end else begin
            tx_send_reg <= tx_send_next;
            tx_data_reg <= tx_data_next;
            q_reg       <= q_next;
            if (tx_send_reg) begin
                gap_cnt_reg <= CW'(GAP_CYCLES);
                last_tx_reg <= tx_data_reg;
            end else if (gap_cnt_reg != '0) begin
                gap_cnt_reg <= gap_cnt_reg - 1'b1;
            end
            if (host_valid && dec_led_wr)  leds_reg     <= dec_led_val;
            if (host_valid && dec_scan_wr) scan_en_reg  <= dec_scan_val;
            if (host_valid && dec_wait_wr) wait_arg_reg <= dec_wait_val;
        end
    end

    assign tx_send      = tx_send_reg;
    assign tx_data      = tx_data_reg;
    assign leds         = leds_reg;
    assign scan_enabled = scan_en_reg;

endmodule

// File: tb/tb_ps2_kbd_scheduler.sv
// Directed bench: expected transmit bytes are queued as stimulus is driven
// and checked in order by a monitor on every tx_send pulse.
module tb_ps2_kbd_scheduler;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] key_scancode = 8'h00;
    logic       key_send = 1'b0;
    logic       key_ready;
    logic [7:0] host_data = 8'h00;
    logic       host_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_send;
    logic [2:0] leds;
    logic       scan_enabled;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_cyc = -1;
    logic [7:0] exp_q[$];

    ps2_kbd_scheduler #(.GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_scancode (key_scancode),
        .key_send     (key_send),
        .key_ready    (key_ready),
        .host_data    (host_data),
        .host_valid   (host_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .leds         (leds),
        .scan_enabled (scan_enabled)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // scoreboard monitor: every transmitted byte must match the queue head
    always @(negedge clk) begin
        if (reset && tx_send) begin
            logic [8:0] expb;
            expb = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h1FF;
            check("tx_byte", {23'd0, 1'b0, tx_data}, {23'd0, expb});
            if (last_cyc >= 0) check("tx_gap", 32'((cyc - last_cyc) >= GAP), 32'd1);
            last_cyc = cyc;
            $display("tx byte=%02h at cycle %0d", tx_data, cyc);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("key_ready_wait", {31'd0, key_ready}, 32'd1);
    endtask

    task automatic send_key(input logic [7:0] b);
        wait_ready();
        exp_q.push_back(b);
        key_scancode = b;
        key_send = 1'b1;
        @(negedge clk);
        key_send = 1'b0;
        $display("key 0x%02h offered", b);
    endtask

    task automatic host(input logic [7:0] b);
        host_data = b;
        host_valid = 1'b1;
        @(negedge clk);
        host_valid = 1'b0;
        $display("host 0x%02h", b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (GAP + 3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_leds", {29'd0, leds}, 32'd0);
        check("rst_scan", {31'd0, scan_enabled}, 32'd1);
        check("rst_key_ready", {31'd0, key_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // single key, then the gap holds key_ready low
        send_key(8'h1C);
        for (int i = 0; i < GAP + 1; i++) begin
            check("kr_gap_low", {31'd0, key_ready}, 32'd0);
            @(negedge clk);
        end
        check("kr_gap_high", {31'd0, key_ready}, 32'd1);
        wait_idle();

        // host reset: FA, AA; a key offered meanwhile follows AA
        exp_q.push_back(8'hFA);
        exp_q.push_back(8'hAA);
        host(8'hFF);
        send_key(8'h33);
        wait_idle();
        check("ff_leds", {29'd0, leds}, 32'd0);
        check("ff_scan", {31'd0, scan_enabled}, 32'd1);

        // set LEDs with argument
        exp_q.push_back(8'hFA);
        host(8'hED);
        wait_idle();
        exp_q.push_back(8'hFA);
        host(8'h05);
        wait_idle();
        check("led_set", {29'd0, leds}, 32'd5);

        // argument replaced by a command
        exp_q.push_back(8'hFA);
        host(8'hED);
        wait_idle();
        exp_q.push_back(8'hEE);
        host(8'hEE);
        wait_idle();
        check("led_keep", {29'd0, leds}, 32'd5);

        // disable / enable scanning
        exp_q.push_back(8'hFA);
        host(8'hF5);
        wait_idle();
        check("scan_off", {31'd0, scan_enabled}, 32'd0);
        repeat (3) begin
            check("kr_disabled", {31'd0, key_ready}, 32'd0);
            @(negedge clk);
        end
        exp_q.push_back(8'hFA);
        host(8'hF4);
        wait_idle();
        check("kr_enabled", {31'd0, key_ready}, 32'd1);

        // read ID interrupted by echo: FA still leaves, AB/83 flushed
        exp_q.push_back(8'hFA);
        exp_q.push_back(8'hEE);
        host(8'hF2);
        host(8'hEE);
        wait_idle();

        // unknown command and an ignored data byte
        exp_q.push_back(8'hFE);
        host(8'hAB);
        wait_idle();
        host(8'h30);
        wait_idle();

        // resend repeats the last transmitted key
        send_key(8'h12);
        wait_idle();
        send_key(8'h1C);
        wait_idle();
        exp_q.push_back(8'h1C);
        host(8'hFE);
        wait_idle();

        // reset with a blocked channel and queued replies
        tx_ready = 1'b0;
        host(8'hF5);
        repeat (3) @(negedge clk);
        check("pre_rst_scan", {31'd0, scan_enabled}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("mid_rst_leds", {29'd0, leds}, 32'd0);
        check("mid_rst_scan", {31'd0, scan_enabled}, 32'd1);
        check("mid_rst_kr", {31'd0, key_ready}, 32'd0);
        reset = 1'b1;
        tx_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_kr", {31'd0, key_ready}, 32'd1);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
